// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam int N_DIGITS = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam logic [N_DIGITS-1:0] AN_OFF = 4'b1111;

  localparam seg_t SEG_HEX [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  assign seg = SEG_HEX[nib];

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed hex display driver with a double-buffered value.
// The display register only reloads on the 3->0 index wrap, so a frame never mixes values.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         in_data,
  input  logic [N_DIGITS-1:0] in_dp,
  input  logic                in_load,
  output seg_t                out_seg,
  output logic                out_dp,
  output logic [N_DIGITS-1:0] out_an,
  output logic                out_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]    cnt;
  logic [1:0]          idx;
  logic                adv;
  logic [15:0]         pend_data;
  logic [N_DIGITS-1:0] pend_dp;
  logic [15:0]         disp_data;
  logic [N_DIGITS-1:0] disp_dp;

  logic                term;
  logic                blank;
  logic [3:0]          nib;
  logic [N_DIGITS-1:0] an_sel;
  seg_t                seg_dec;

  // Outputs are built from the pre-edge index, so each slot appears one edge
  // after the index register moves and lasts exactly REFRESH_DIV cycles.
  always_comb begin
    term   = (cnt == CNT_LAST);
    nib    = disp_data[{idx, 2'b00} +: 4];
    an_sel = ~(4'b0001 << idx);
    blank  = 1'b0;
    if (BLANK_LZ) begin
      case (idx)
        2'd1:    blank = (disp_data[15:4]  == 12'h000);
        2'd2:    blank = (disp_data[15:8]  == 8'h00);
        2'd3:    blank = (disp_data[15:12] == 4'h0);
        default: blank = 1'b0;
      endcase
    end
  end

  hex_to_seg7 u_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      adv       <= 1'b0;
      pend_data <= '0;
      pend_dp   <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
      out_an    <= AN_OFF;
      out_seg   <= SEG_BLANK;
      out_dp    <= 1'b1;
      out_tick  <= 1'b0;
    end else begin
      cnt      <= term ? '0 : cnt + 1'b1;
      adv      <= term;
      out_tick <= adv;
      if (term) idx <= idx + 2'd1;
      if (in_load) begin
        pend_data <= in_data;
        pend_dp   <= in_dp;
      end
      // On the wrap edge the display takes the pending value from before this edge.
      if (term && idx == 2'd3) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
      end
      if (blank) begin
        out_an  <= AN_OFF;
        out_seg <= SEG_BLANK;
        out_dp  <= 1'b1;
      end else begin
        out_an  <= an_sel;
        out_seg <= seg_dec;
        out_dp  <= ~disp_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan with REFRESH_DIV=4, blanking on and off side by side.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_dp;
  logic        in_load;

  logic [6:0]  seg_b, seg_n;
  logic        dp_b, dp_n;
  logic [3:0]  an_b, an_n;
  logic        tick_b, tick_n;

  int test_cnt = 0;
  int fail_cnt = 0;

  typedef struct {
    logic [3:0] an_b;
    logic [6:0] seg_b;
    logic       dp_b;
    logic [3:0] an_nb;
    logic [6:0] seg_nb;
    logic       dp_nb;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  logic        mon_on  = 1'b0;
  logic        first_m = 1'b0;
  int          slot_len = 0;

  logic [15:0] pend_v, disp_v;
  logic [3:0]  pend_d, disp_d;

  always #5 clk = ~clk;

  seg7_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dp(in_dp), .in_load(in_load),
    .out_seg(seg_b), .out_dp(dp_b), .out_an(an_b), .out_tick(tick_b)
  );

  seg7_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dp(in_dp), .in_load(in_load),
    .out_seg(seg_n), .out_dp(dp_n), .out_an(an_n), .out_tick(tick_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic exp_t mk(input logic [15:0] v, input logic [3:0] d, input int k);
    exp_t       e;
    logic [3:0] one_hot;
    logic [3:0] nib;
    logic       blank;
    one_hot  = 4'b0001 << k;
    nib      = 4'(v >> (4 * k));
    blank    = (k > 0) && ((v >> (4 * k)) == 16'h0000);
    e.an_nb  = ~one_hot;
    e.seg_nb = hex_seg(nib);
    e.dp_nb  = ~d[k];
    e.an_b   = blank ? 4'hF : ~one_hot;
    e.seg_b  = blank ? 7'h7F : hex_seg(nib);
    e.dp_b   = blank ? 1'b1 : ~d[k];
    return e;
  endfunction

  // Monitor samples 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (mon_on) begin
      if (first_m || tick_b) begin
        if (!first_m) begin
          chk("slot_len", slot_len, 4);
          chk("tick_nb", tick_n, 1);
        end
        chk("q_nonempty", (q.size() != 0), 1);
        if (q.size() != 0) cur = q.pop_front();
        chk("an_b", an_b, cur.an_b);
        chk("seg_b", seg_b, cur.seg_b);
        chk("dp_b", dp_b, cur.dp_b);
        chk("an_nb", an_n, cur.an_nb);
        chk("seg_nb", seg_n, cur.seg_nb);
        chk("dp_nb", dp_n, cur.dp_nb);
        first_m  = 1'b0;
        slot_len = 1;
      end else begin
        slot_len++;
        if (slot_len > 4) chk("tick_missing", slot_len, 4);
        chk("hold_an_b", an_b, cur.an_b);
        chk("hold_seg_b", seg_b, cur.seg_b);
        chk("hold_an_nb", an_n, cur.an_nb);
        chk("tick_nb_low", tick_n, 0);
      end
    end
  end

  task automatic do_reset(input int n);
    rst_n   = 1'b0;
    in_load = 1'b0;
    mon_on  = 1'b0;
    q.delete();
    pend_v = '0; pend_d = '0; disp_v = '0; disp_d = '0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_an_b", an_b, 4'hF);
      chk("rst_seg_b", seg_b, 7'h7F);
      chk("rst_dp_b", dp_b, 1);
      chk("rst_tick_b", tick_b, 0);
      chk("rst_an_nb", an_n, 4'hF);
      chk("rst_seg_nb", seg_n, 7'h7F);
    end
    rst_n    = 1'b1;
    first_m  = 1'b1;
    slot_len = 0;
    mon_on   = 1'b1;
  endtask

  // One frame of 16 edges; offset 15 is the wrap edge. Loads at o1/o2, reset at rst_at.
  task automatic run_frame(input logic [15:0] v1, input logic [3:0] d1, input int o1,
                           input logic [15:0] v2, input int o2, input int rst_at);
    logic [15:0] nd_v;
    logic [3:0]  nd_d;
    nd_v = disp_v;
    nd_d = disp_d;
    for (int k = 0; k < 4; k++) q.push_back(mk(disp_v, disp_d, k));
    for (int o = 0; o < 16; o++) begin
      if (o == rst_at) begin
        do_reset(2);
        return;
      end
      if (o == 15) begin
        nd_v = pend_v;
        nd_d = pend_d;
      end
      if (o == o1) begin
        in_load = 1'b1; in_data = v1; in_dp = d1;
        pend_v = v1; pend_d = d1;
      end else if (o == o2) begin
        in_load = 1'b1; in_data = v2; in_dp = 4'b0000;
        pend_v = v2; pend_d = 4'b0000;
      end else begin
        in_load = 1'b0;
        in_data = 16'($urandom);
        in_dp   = 4'($urandom);
      end
      @(negedge clk);
    end
    in_load = 1'b0;
    disp_v = nd_v;
    disp_d = nd_d;
  endtask

  initial begin
    rst_n   = 1'b0;
    in_load = 1'b0;
    in_data = '0;
    in_dp   = '0;
    @(negedge clk);
    do_reset(3);
    run_frame(16'h0, 4'h0, -1, 16'h0, -1, -1);           // shows 0, upper slots dark
    run_frame(16'h1A3F, 4'b0100, 5, 16'h0, -1, -1);      // load 1A3F
    run_frame(16'h0040, 4'b0000, 3, 16'h0, -1, -1);      // shows 1A3F, load 0040
    run_frame(16'h1111, 4'b0000, 5, 16'h2222, 9, -1);    // shows 0040, two loads
    run_frame(16'h00FF, 4'b0000, 15, 16'h0, -1, -1);     // shows 2222, load on wrap
    run_frame(16'h0, 4'h0, -1, 16'h0, -1, -1);           // still 2222
    run_frame(16'h0BCD, 4'b0001, 14, 16'h0, -1, -1);     // shows 00FF, late load
    run_frame(16'h0, 4'h0, -1, 16'h0, -1, 10);           // shows 0BCD, reset in slot 2
    run_frame(16'h0, 4'h0, -1, 16'h0, -1, -1);           // restart at 0
    run_frame(16'h0, 4'h0, -1, 16'h0, -1, -1);           // pending cleared too
    mon_on = 1'b0;
    chk("q_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
